// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and RV opcode constants for the operand fetch stage.
package operand_fetch_stage_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef logic [XLEN_DEFAULT-1:0] word_t;
    typedef logic [4:0]              reg_addr_t;
    typedef logic [6:0]              opcode_t;

    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_OP32   = 7'b0111011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/operand_fetch_stage_fwd_sel.sv
// Priority selection of the youngest pending write to one register address.
module fwd_sel
    import operand_fetch_stage_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int XLEN    = XLEN_DEFAULT
) (
    input  reg_addr_t                       i_addr,
    input  logic [NUM_FWD-1:0]              i_fwd_valid,
    input  logic [NUM_FWD-1:0][4:0]         i_fwd_addr,
    input  logic [NUM_FWD-1:0][XLEN-1:0]    i_fwd_data,
    input  logic [NUM_FWD-1:0]              i_fwd_ok,
    output logic                            o_hit,
    output logic                            o_ok,
    output logic [XLEN-1:0]                 o_data
);

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        o_hit  = 1'b0;
        o_ok   = 1'b0;
        o_data = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_fwd_valid[i] && (i_fwd_addr[i] != 5'd0) && (i_fwd_addr[i] == i_addr)) begin
                o_hit  = 1'b1;
                o_ok   = i_fwd_ok[i];
                o_data = i_fwd_data[i];
            end
        end
    end

endmodule

// File: rtl/operand_fetch_stage_src_usage.sv
// Decodes which source register fields an instruction actually reads.
module src_usage
    import operand_fetch_stage_pkg::*;
(
    input  logic [31:0] inst,
    output logic        use_rs1,
    output logic        use_rs2
);

    opcode_t w_opc;
    logic    w_unused;

    assign w_opc    = inst[6:0];
    assign w_unused = ^inst[31:7];

    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL:            use_rs1 = 1'b0;
            OPC_OP, OPC_OP32, OPC_STORE, OPC_BRANCH: use_rs2 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: resolves rs1/rs2 through the forwarding network, stalls on
// not-yet-final forwards, and registers the result behind a ready/valid skid-free stage.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_inst,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [31:0][XLEN-1:0]        regs_value,
    input  logic [NUM_FWD-1:0]           fwd_valid,
    input  logic [NUM_FWD-1:0][4:0]      fwd_addr,
    input  logic [NUM_FWD-1:0][XLEN-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]           fwd_data_ok,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_inst,
    output logic [XLEN-1:0]              out_pc,
    output logic [4:0]                   out_rs1_addr,
    output logic [4:0]                   out_rs2_addr,
    output logic [XLEN-1:0]              out_rs1_val,
    output logic [XLEN-1:0]              out_rs2_val,
    output logic [CNT_W-1:0]             stall_count
);

    reg_addr_t         w_rs1, w_rs2;
    logic              w_use_rs1, w_use_rs2;
    logic              w_hit1, w_hit2, w_ok1, w_ok2;
    logic [XLEN-1:0]   w_fdata1, w_fdata2, w_rs1_val, w_rs2_val;
    logic              w_hazard, w_load_en, w_xfer;

    logic              r_valid;
    logic [31:0]       r_inst;
    logic [XLEN-1:0]   r_pc, r_rs1_val, r_rs2_val;
    reg_addr_t         r_rs1, r_rs2;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_rs1 = in_inst[19:15];
    assign w_rs2 = in_inst[24:20];

    src_usage u_usage (
        .inst    (in_inst),
        .use_rs1 (w_use_rs1),
        .use_rs2 (w_use_rs2)
    );

    fwd_sel #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs1 (
        .i_addr(w_rs1), .i_fwd_valid(fwd_valid), .i_fwd_addr(fwd_addr),
        .i_fwd_data(fwd_data), .i_fwd_ok(fwd_data_ok),
        .o_hit(w_hit1), .o_ok(w_ok1), .o_data(w_fdata1)
    );

    fwd_sel #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs2 (
        .i_addr(w_rs2), .i_fwd_valid(fwd_valid), .i_fwd_addr(fwd_addr),
        .i_fwd_data(fwd_data), .i_fwd_ok(fwd_data_ok),
        .o_hit(w_hit2), .o_ok(w_ok2), .o_data(w_fdata2)
    );

    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : (w_hit1 ? w_fdata1 : regs_value[w_rs1]);
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : (w_hit2 ? w_fdata2 : regs_value[w_rs2]);

    // A younger not-ready match stalls even if an older source has final data.
    assign w_hazard  = in_valid & ~flush &
                       ((w_use_rs1 & w_hit1 & ~w_ok1) | (w_use_rs2 & w_hit2 & ~w_ok2));
    assign w_load_en = ~r_valid | out_ready;
    assign in_ready  = w_load_en & ~w_hazard & ~flush;
    assign w_xfer    = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= 1'b0;
            r_inst      <= '0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load_en) begin
                r_valid <= w_xfer;
                if (w_xfer) begin
                    r_inst    <= in_inst;
                    r_pc      <= in_pc;
                    r_rs1     <= w_rs1;
                    r_rs2     <= w_rs2;
                    r_rs1_val <= w_rs1_val;
                    r_rs2_val <= w_rs2_val;
                end
            end
            if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid    = r_valid;
    assign out_inst     = r_inst;
    assign out_pc       = r_pc;
    assign out_rs1_addr = r_rs1;
    assign out_rs2_addr = r_rs2;
    assign out_rs1_val  = r_rs1_val;
    assign out_rs2_val  = r_rs2_val;
    assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed + random bench for operand_fetch_stage against a first-match reference model.
module tb_operand_fetch_stage;

    localparam int NF = 3;
    localparam int XL = 64;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]             in_inst, out_inst;
    logic [XL-1:0]           in_pc, out_pc, out_rs1_val, out_rs2_val;
    logic [31:0][XL-1:0]     regs_value;
    logic [NF-1:0]           fwd_valid, fwd_data_ok;
    logic [NF-1:0][4:0]      fwd_addr;
    logic [NF-1:0][XL-1:0]   fwd_data;
    logic [4:0]              out_rs1_addr, out_rs2_addr;
    logic [CW-1:0]           stall_count;

    int checks = 0;
    int failures = 0;

    logic          e_valid;
    logic [31:0]   e_inst;
    logic [XL-1:0] e_pc, e_v1, e_v2;
    int            e_cnt;

    operand_fetch_stage #(.NUM_FWD(NF), .XLEN(XL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .regs_value(regs_value),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_data_ok(fwd_data_ok), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, opc};
    endfunction

    // Reference: which operands an opcode reads.
    function automatic void m_uses(input logic [6:0] opc, output logic u1, output logic u2);
        u1 = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = opc inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
    endfunction

    // Reference: youngest pending write wins, x0 is hardwired zero.
    function automatic logic [63:0] m_read(input logic [4:0] a, output logic pend);
        pend = 1'b0;
        if (a == 5'd0) return 64'd0;
        for (int i = 0; i < NF; i++)
            if (fwd_valid[i] && fwd_addr[i] == a) begin
                pend = !fwd_data_ok[i];
                return fwd_data[i];
            end
        return regs_value[a];
    endfunction

    task automatic m_reset();
        e_valid = 0; e_inst = 0; e_pc = 0; e_v1 = 0; e_v2 = 0; e_cnt = 0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, e_valid});
        check({tag, ".stall"}, {60'd0, stall_count}, e_cnt);
        check({tag, ".inst"}, {32'd0, out_inst}, {32'd0, e_inst});
        check({tag, ".pc"}, out_pc, e_pc);
        check({tag, ".rs1a"}, {59'd0, out_rs1_addr}, {59'd0, e_inst[19:15]});
        check({tag, ".rs2a"}, {59'd0, out_rs2_addr}, {59'd0, e_inst[24:20]});
        check({tag, ".rs1v"}, out_rs1_val, e_v1);
        check({tag, ".rs2v"}, out_rs2_val, e_v2);
    endtask

    // Inputs are already driven; predict ready, clock once, then compare.
    task automatic cycle(input string tag);
        logic u1, u2, p1, p2, haz, ld, rdy;
        logic [63:0] v1, v2;
        #1;
        m_uses(in_inst[6:0], u1, u2);
        v1 = m_read(in_inst[19:15], p1);
        v2 = m_read(in_inst[24:20], p2);
        haz = in_valid && !flush && ((u1 && p1) || (u2 && p2));
        ld  = !e_valid || out_ready;
        rdy = ld && !haz && !flush;
        check({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
        @(posedge clk);
        if (haz && e_cnt < CMAX) e_cnt++;
        if (flush) e_valid = 0;
        else if (ld) begin
            e_valid = in_valid && rdy;
            if (e_valid) begin
                e_inst = in_inst; e_pc = in_pc; e_v1 = v1; e_v2 = v2;
            end
        end
        #1;
        check_outs(tag);
    endtask

    task automatic clear_fwd();
        fwd_valid = '0; fwd_addr = '0; fwd_data = '0; fwd_data_ok = '1;
    endtask

    initial begin
        logic [6:0] opcs [8];
        opcs = '{7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011,
                 7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};
        reset = 0; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 1;
        clear_fwd();
        for (int i = 0; i < 32; i++) regs_value[i] = {$urandom, $urandom};
        regs_value[0] = 64'hDEAD;
        m_reset();
        #12;
        check_outs("reset");
        @(posedge clk); #1 reset = 1;

        // add x3,x1,x2 with no forwards
        regs_value[1] = 64'd5; regs_value[2] = 64'd7;
        in_valid = 1; in_pc = 64'h1000; in_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2);
        cycle("add");
        check("add.v1", out_rs1_val, 64'd5);
        check("add.v2", out_rs2_val, 64'd7);

        // two sources to x1, youngest wins
        fwd_valid = 3'b101; fwd_addr[0] = 5'd1; fwd_addr[2] = 5'd1;
        fwd_data[0] = 64'hAA; fwd_data[2] = 64'hBB;
        in_pc = 64'h1004;
        cycle("prio");
        check("prio.v1", out_rs1_val, 64'hAA);

        // load-use stall on x2 via source 1
        clear_fwd();
        fwd_valid = 3'b010; fwd_addr[1] = 5'd2; fwd_data_ok[1] = 1'b0; fwd_data[1] = 64'h42;
        in_pc = 64'h1008;
        for (int k = 0; k < 3; k++) cycle("stall");
        check("stall.cnt", {60'd0, stall_count}, 64'd3);
        fwd_data_ok[1] = 1'b1;
        cycle("stall.rel");
        check("stall.v2", out_rs2_val, 64'h42);
        check("stall.cnt2", {60'd0, stall_count}, 64'd3);

        // unused or x0 operands never stall; x0 reads zero
        clear_fwd();
        fwd_valid = 3'b011; fwd_addr[0] = 5'd0; fwd_data_ok[0] = 1'b0; fwd_data[0] = 64'd9;
        fwd_addr[1] = 5'd2; fwd_data_ok[1] = 1'b0;
        in_inst = mk(7'b0110111, 5'd5, 5'd0, 5'd2); in_pc = 64'h100C;
        cycle("lui");
        check("lui.acc", {63'd0, out_valid}, 64'd1);
        fwd_data_ok[0] = 1'b1;
        in_inst = mk(7'b0010011, 5'd4, 5'd0, 5'd2); in_pc = 64'h1010;
        cycle("addi");
        check("addi.v1", out_rs1_val, 64'd0);

        // younger not-ready match must not be bypassed by older ready one
        clear_fwd();
        fwd_valid = 3'b101; fwd_addr[0] = 5'd1; fwd_addr[2] = 5'd1; fwd_data_ok[0] = 1'b0;
        in_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd6); in_pc = 64'h1014;
        cycle("young");
        check("young.rdy", {63'd0, in_ready}, 64'd0);

        // hold the hazard until the counter saturates
        for (int k = 0; k < 14; k++) cycle("sat");
        check("sat.cnt", {60'd0, stall_count}, 64'd15);

        // backpressure: outputs stable, in_ready low
        clear_fwd();
        in_inst = mk(7'b0110011, 5'd7, 5'd8, 5'd9); in_pc = 64'h2000;
        cycle("bp.load");
        out_ready = 0; in_inst = mk(7'b0110011, 5'd10, 5'd11, 5'd12); in_pc = 64'h2004;
        for (int k = 0; k < 4; k++) cycle("bp");
        check("bp.pc", out_pc, 64'h2000);
        flush = 1;
        cycle("flush");
        check("flush.v", {63'd0, out_valid}, 64'd0);
        flush = 0; out_ready = 1;

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NF; i++) begin
                fwd_valid[i]   = $urandom_range(0, 1);
                fwd_addr[i]    = 5'($urandom_range(0, 3));
                fwd_data[i]    = {$urandom, $urandom};
                fwd_data_ok[i] = ($urandom_range(0, 3) != 0);
            end
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_inst   = mk(opcs[$urandom_range(0, 7)], 5'($urandom_range(0, 31)),
                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            in_pc     = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) regs_value[$urandom_range(1, 3)] = {$urandom, $urandom};
            cycle("rand");
        end

        // asynchronous reset in the middle of a cycle
        clear_fwd(); flush = 0; out_ready = 1; in_valid = 1;
        fwd_valid = 3'b001; fwd_addr[0] = 5'd1; fwd_data_ok[0] = 1'b0;
        in_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2);
        cycle("pre_rst");
        clear_fwd(); in_pc = 64'h3000;
        cycle("pre_rst2");
        #2 reset = 0;
        #1;
        m_reset();
        check("arst.v", {63'd0, out_valid}, 64'd0);
        check("arst.cnt", {60'd0, stall_count}, 64'd0);
        check_outs("arst");
        @(posedge clk); #1 reset = 1;
        in_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2); in_pc = 64'h4000;
        cycle("post_rst");
        check("post_rst.pc", out_pc, 64'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
